maze_game_ctrl: RTL and testbench
=================================

Name: maze_game_ctrl

Overview:
Game-sequencing controller for the tilt maze. Owns the ball position registers and advances them once per video frame from accelerometer tilt, gated by the maze collision stop flags. Runs the IDLE/PLAY/WIN/LOSE game flow with goal detection, a per-second play timer and a time limit. Feeds x_ball/y_ball to the maze portion collision logic and the ball sprite renderer.

Parameters:
START_X, 40, ball x after reset or restart (pixels)
START_Y, 0, ball y after reset or restart (pixels)
X_MAX, 620, maximum legal x_ball
Y_MAX, 460, maximum legal y_ball
GOAL_X0, 576, goal window x lower bound, inclusive
GOAL_X1, 589, goal window x upper bound, inclusive
GOAL_Y0, 451, goal window y lower bound, inclusive
GOAL_Y1, 499, goal window y upper bound, inclusive
DEADZONE, 8, |tilt| at or below this gives no motion
FAST_THRESH, 64, |tilt| above this gives step 2, otherwise step 1
FRAMES_PER_SEC, 60, frame_tick pulses per timer second
TIME_LIMIT, 99, seconds of play before LOSE
HOLD_FRAMES, 120, frames WIN/LOSE is held before returning to IDLE

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
frame_tick  in  1  one-cycle pulse per frame (start of vertical blank)
start  in  1  one-cycle start/restart request
x_tilt  in  10  accelerometer X, two's complement
y_tilt  in  10  accelerometer Y, two's complement
stop_left  in  1  collision: leftward move blocked
stop_right  in  1  collision: rightward move blocked
stop_up  in  1  collision: upward move blocked
stop_down  in  1  collision: downward move blocked
x_ball  out  11  ball x position, registered
y_ball  out  11  ball y position, registered
state  out  2  0=IDLE 1=PLAY 2=WIN 3=LOSE
seconds  out  8  elapsed play seconds, registered
win  out  1  high while in WIN
lose  out  1  high while in LOSE

Behaviour:
- Reset (rst sampled high at clk edge): state=IDLE, x_ball=START_X, y_ball=START_Y, seconds=0, frame counter=0, hold counter=0, win=0, lose=0. rst overrides all other inputs.
- Magnitude: |v| = v if v[9]=0, else (~v+1) as 10-bit unsigned. -512 gives 512. Step = 0 if |v|<=DEADZONE; 1 if DEADZONE<|v|<=FAST_THRESH; 2 if |v|>FAST_THRESH. Direction: v[9]=1 means left/up, v[9]=0 means right/down.
- Motion happens only in PLAY and only on cycles with frame_tick=1. New position is visible on outputs the cycle after the tick. Between ticks the position is held.
- Per axis, the stop flag for the commanded direction suppresses the move (step forced to 0). The opposite-direction stop flag has no effect. X and Y update in the same cycle, independently.
- Saturation: a decrement below 0 clamps to 0. An increment above X_MAX or Y_MAX clamps to the max. Example: x_ball=619 with step 2 gives 620.
- IDLE: position held at START. On start=1, go to PLAY with seconds=0 and frame counter=0. No motion occurs on the transition cycle, even if frame_tick is also high.
- PLAY, on each frame_tick:
  - Goal check uses the registered position before the update. If it is inside the goal window (all bounds inclusive), go to WIN and do not move.
  - Otherwise advance the frame counter. When it reaches FRAMES_PER_SEC-1, wrap it to 0 and increment seconds.
  - If the incremented seconds equals TIME_LIMIT, go to LOSE. The move for that frame is still applied.
  - Goal has priority over timeout in the same frame.
  - seconds saturates at 255.
- PLAY plus start=1: restart. Position returns to START, seconds=0, state stays PLAY. This has priority over frame_tick in the same cycle.
- WIN/LOSE: position and seconds frozen, hold counter cleared on entry. Each frame_tick increments the hold counter. After HOLD_FRAMES ticks, go to IDLE and reset position to START. start=1 in WIN/LOSE goes immediately to PLAY as in IDLE.
- win = (state==WIN) and lose = (state==LOSE), both registered with state.
- Tilt and stop inputs are sampled only on frame_tick cycles. No handshake; all outputs are valid every cycle.

Test Plan:
- Reset then idle: rst 1 cycle, frame_tick every 10 cycles, x_tilt=+200 -> state=0, x_ball=40, y_ball=0 held for 20 ticks, seconds=0.
- Step sizing: start, then x_tilt=+5 for 3 ticks, then +30 for 3 ticks, then -200 (10'h338) for 2 ticks -> x_ball goes 40, 40, 40, 43 (after the +30 ticks), 39; y_ball=0 with y_tilt=0.
- Collision and clamp: stop_right=1 with x_tilt=+100 for 5 ticks -> x_ball unchanged; y_tilt=-100 at y_ball=0 -> stays 0; x_ball=619 with step 2 -> 620.
- Goal: drive the ball to (580,460) -> state=2 and win=1 on the next tick, position frozen; after 120 ticks state=0 and position=(40,0).
- Timeout: FRAMES_PER_SEC=2, TIME_LIMIT=3 with the ball outside the goal -> seconds 1, 2, 3 on ticks 2, 4, 6; state=3 after tick 6; lose=1.
- Simultaneous events: in PLAY assert start and frame_tick together with x_tilt=+100 -> x_ball=40, seconds=0; in IDLE start with frame_tick -> PLAY, no motion; goal and timeout on the same tick -> WIN.

Source files
------------

// File: rtl/maze_game_ctrl.sv
// Tilt-maze game sequencer: owns the ball position, applies per-frame tilt motion
// gated by collision stops, and runs the IDLE/PLAY/WIN/LOSE flow with timer and goal.
module maze_game_ctrl #(
  parameter int unsigned START_X        = 40,
  parameter int unsigned START_Y        = 0,
  parameter int unsigned X_MAX          = 620,
  parameter int unsigned Y_MAX          = 460,
  parameter int unsigned GOAL_X0        = 576,
  parameter int unsigned GOAL_X1        = 589,
  parameter int unsigned GOAL_Y0        = 451,
  parameter int unsigned GOAL_Y1        = 499,
  parameter int unsigned DEADZONE       = 8,
  parameter int unsigned FAST_THRESH    = 64,
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned TIME_LIMIT     = 99,
  parameter int unsigned HOLD_FRAMES    = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [9:0]  x_tilt,
  input  logic [9:0]  y_tilt,
  input  logic        stop_left,
  input  logic        stop_right,
  input  logic        stop_up,
  input  logic        stop_down,
  output logic [10:0] x_ball,
  output logic [10:0] y_ball,
  output logic [1:0]  state,
  output logic [7:0]  seconds,
  output logic        win,
  output logic        lose
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_WIN  = 2'd2,
    S_LOSE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [7:0]  sec_q, sec_d;
  logic [15:0] frame_q, frame_d;
  logic [15:0] hold_q, hold_d;
  logic        win_q, win_d, lose_q, lose_d;

  logic [10:0] x_next, y_next;
  logic [7:0]  sec_inc;
  logic        in_goal;

  // -512 maps to 512 because the result stays 10 bits wide
  function automatic logic [9:0] tilt_mag(input logic [9:0] v);
    return v[9] ? (~v + 10'd1) : v;
  endfunction

  function automatic logic [1:0] tilt_step(input logic [9:0] v);
    logic [9:0] m;
    m = tilt_mag(v);
    if (m <= 10'(DEADZONE))         return 2'd0;
    else if (m <= 10'(FAST_THRESH)) return 2'd1;
    else                            return 2'd2;
  endfunction

  function automatic logic [10:0] axis_next(input logic [10:0] pos,
                                            input logic [9:0]  tilt,
                                            input logic        stop_neg,
                                            input logic        stop_pos,
                                            input logic [10:0] max_pos);
    logic [1:0]  step;
    logic [11:0] sum;
    step = tilt_step(tilt);
    if (tilt[9]) begin
      if (stop_neg) step = 2'd0;
      return (pos < 11'(step)) ? '0 : pos - 11'(step);
    end else begin
      if (stop_pos) step = 2'd0;
      sum = {1'b0, pos} + 12'(step);
      return (sum > {1'b0, max_pos}) ? max_pos : sum[10:0];
    end
  endfunction

  always_comb begin
    x_next  = axis_next(x_q, x_tilt, stop_left, stop_right, 11'(X_MAX));
    y_next  = axis_next(y_q, y_tilt, stop_up,   stop_down,  11'(Y_MAX));
    sec_inc = (sec_q == 8'hFF) ? 8'hFF : sec_q + 8'd1;
    in_goal = (x_q >= 11'(GOAL_X0)) && (x_q <= 11'(GOAL_X1)) &&
              (y_q >= 11'(GOAL_Y0)) && (y_q <= 11'(GOAL_Y1));

    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    sec_d   = sec_q;
    frame_d = frame_q;
    hold_d  = hold_q;

    unique case (state_q)
      S_IDLE: begin
        x_d = 11'(START_X);
        y_d = 11'(START_Y);
        if (start) begin
          state_d = S_PLAY;
          sec_d   = '0;
          frame_d = '0;
          hold_d  = '0;
        end
      end
      S_PLAY: begin
        if (start) begin
          x_d     = 11'(START_X);
          y_d     = 11'(START_Y);
          sec_d   = '0;
          frame_d = '0;
        end else if (frame_tick) begin
          // goal is judged on the pre-move position and wins over timeout
          if (in_goal) begin
            state_d = S_WIN;
            hold_d  = '0;
          end else begin
            x_d = x_next;
            y_d = y_next;
            if (frame_q == 16'(FRAMES_PER_SEC - 1)) begin
              frame_d = '0;
              sec_d   = sec_inc;
              if (sec_inc == 8'(TIME_LIMIT)) begin
                state_d = S_LOSE;
                hold_d  = '0;
              end
            end else begin
              frame_d = frame_q + 16'd1;
            end
          end
        end
      end
      S_WIN, S_LOSE: begin
        if (start) begin
          state_d = S_PLAY;
          x_d     = 11'(START_X);
          y_d     = 11'(START_Y);
          sec_d   = '0;
          frame_d = '0;
          hold_d  = '0;
        end else if (frame_tick) begin
          if (hold_q == 16'(HOLD_FRAMES - 1)) begin
            state_d = S_IDLE;
            x_d     = 11'(START_X);
            y_d     = 11'(START_Y);
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 16'd1;
          end
        end
      end
    endcase

    win_d  = (state_d == S_WIN);
    lose_d = (state_d == S_LOSE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= 11'(START_X);
      y_q     <= 11'(START_Y);
      sec_q   <= '0;
      frame_q <= '0;
      hold_q  <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sec_q   <= sec_d;
      frame_q <= frame_d;
      hold_q  <= hold_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
    end
  end

  assign x_ball  = x_q;
  assign y_ball  = y_q;
  assign state   = state_q;
  assign seconds = sec_q;
  assign win     = win_q;
  assign lose    = lose_q;

endmodule

// File: tb/tb_maze_game_ctrl.sv
// Directed vector bench for maze_game_ctrl: a default-parameter instance for motion,
// clamping and goal, plus a near-goal, short-timer instance for timeout corner cases.
module tb_maze_game_ctrl;

  logic        clk;
  logic        rst;
  logic        frame_tick;
  logic        start;
  logic [9:0]  x_tilt, y_tilt;
  logic        stop_left, stop_right, stop_up, stop_down;

  logic [10:0] xa, ya, xb, yb;
  logic [1:0]  sta, stb;
  logic [7:0]  seca, secb;
  logic        wina, losea, winb, loseb;

  int total = 0;
  int bad   = 0;

  maze_game_ctrl dut_a (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .x_tilt(x_tilt), .y_tilt(y_tilt),
    .stop_left(stop_left), .stop_right(stop_right), .stop_up(stop_up), .stop_down(stop_down),
    .x_ball(xa), .y_ball(ya), .state(sta), .seconds(seca), .win(wina), .lose(losea)
  );

  maze_game_ctrl #(
    .START_X(578), .START_Y(446), .FRAMES_PER_SEC(2), .TIME_LIMIT(3), .HOLD_FRAMES(4)
  ) dut_b (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .x_tilt(x_tilt), .y_tilt(y_tilt),
    .stop_left(stop_left), .stop_right(stop_right), .stop_up(stop_up), .stop_down(stop_down),
    .x_ball(xb), .y_ball(yb), .state(stb), .seconds(secb), .win(winb), .lose(loseb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         do_start;
    logic [9:0] xt;
    logic [9:0] yt;
    logic [3:0] stops;   // {left, right, up, down}
    int         nticks;
    int         ex, ey, est, esec;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mkv(string n, bit s, logic [9:0] xt, logic [9:0] yt,
                               logic [3:0] st, int nt, int ex, int ey, int es, int esec);
    vec_t v;
    v.name = n; v.do_start = s; v.xt = xt; v.yt = yt; v.stops = st;
    v.nticks = nt; v.ex = ex; v.ey = ey; v.est = es; v.esec = esec;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_a(input string nm, input int ex, input int ey, input int es, input int esec);
    chk({nm, ".x"},    int'(xa),    ex);
    chk({nm, ".y"},    int'(ya),    ey);
    chk({nm, ".st"},   int'(sta),   es);
    chk({nm, ".sec"},  int'(seca),  esec);
    chk({nm, ".win"},  int'(wina),  (es == 2) ? 1 : 0);
    chk({nm, ".lose"}, int'(losea), (es == 3) ? 1 : 0);
  endtask

  task automatic check_b(input string nm, input int ex, input int ey, input int es, input int esec);
    chk({nm, ".x"},    int'(xb),    ex);
    chk({nm, ".y"},    int'(yb),    ey);
    chk({nm, ".st"},   int'(stb),   es);
    chk({nm, ".sec"},  int'(secb),  esec);
    chk({nm, ".win"},  int'(winb),  (es == 2) ? 1 : 0);
    chk({nm, ".lose"}, int'(loseb), (es == 3) ? 1 : 0);
  endtask

  task automatic tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start(input bit with_tick);
    @(negedge clk); start = 1'b1; frame_tick = with_tick;
    @(negedge clk); start = 1'b0; frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic set_in(input logic [9:0] xt, input logic [9:0] yt, input logic [3:0] st);
    x_tilt = xt; y_tilt = yt;
    {stop_left, stop_right, stop_up, stop_down} = st;
  endtask

  initial begin
    rst = 1'b0; frame_tick = 1'b0; start = 1'b0;
    set_in(10'd0, 10'd0, 4'b0000);

    vecs[0]  = mkv("idle_hold",  0, 10'd200, 10'd0,   4'b0000,  20,  40,   0, 0, 0);
    vecs[1]  = mkv("dead5",      1, 10'd5,   10'd0,   4'b0000,   3,  40,   0, 1, 0);
    vecs[2]  = mkv("slow30",     0, 10'd30,  10'd0,   4'b0000,   3,  43,   0, 1, 0);
    vecs[3]  = mkv("fast_n200",  0, 10'h338, 10'd0,   4'b0000,   2,  39,   0, 1, 0);
    vecs[4]  = mkv("dz_p8",      0, 10'd8,   10'd0,   4'b0000,   1,  39,   0, 1, 0);
    vecs[5]  = mkv("p9",         0, 10'd9,   10'd0,   4'b0000,   1,  40,   0, 1, 0);
    vecs[6]  = mkv("p64",        0, 10'd64,  10'd0,   4'b0000,   1,  41,   0, 1, 0);
    vecs[7]  = mkv("p65",        0, 10'd65,  10'd0,   4'b0000,   1,  43,   0, 1, 0);
    vecs[8]  = mkv("n512",       0, 10'h200, 10'd0,   4'b0000,   1,  41,   0, 1, 0);
    vecs[9]  = mkv("dz_n8",      0, 10'h3F8, 10'd0,   4'b0000,   1,  41,   0, 1, 0);
    vecs[10] = mkv("n9",         0, 10'h3F7, 10'd0,   4'b0000,   1,  40,   0, 1, 0);
    vecs[11] = mkv("stop_r",     0, 10'd100, 10'd0,   4'b0100,   5,  40,   0, 1, 0);
    vecs[12] = mkv("stop_l_opp", 0, 10'd100, 10'd0,   4'b1000,   1,  42,   0, 1, 0);
    vecs[13] = mkv("clamp_y0",   0, 10'd0,   10'h39C, 4'b0000,   2,  42,   0, 1, 0);
    vecs[14] = mkv("stop_dn",    0, 10'd0,   10'd100, 4'b0001,   2,  42,   0, 1, 0);
    vecs[15] = mkv("stop_up_opp",0, 10'd0,   10'd100, 4'b0010,   1,  42,   2, 1, 0);
    vecs[16] = mkv("both_neg",   0, 10'h39C, 10'h39C, 4'b1000,   1,  42,   0, 1, 0);
    vecs[17] = mkv("run_right",  0, 10'd100, 10'd0,   4'b0000, 288, 618,   0, 1, 5);
    vecs[18] = mkv("to619",      0, 10'd30,  10'd0,   4'b0000,   1, 619,   0, 1, 5);
    vecs[19] = mkv("clamp620",   0, 10'd100, 10'd0,   4'b0000,   1, 620,   0, 1, 5);
    vecs[20] = mkv("hold620",    0, 10'd100, 10'd0,   4'b0000,   1, 620,   0, 1, 5);
    vecs[21] = mkv("run_down",   0, 10'd0,   10'd100, 4'b0000, 230, 620, 460, 1, 9);
    vecs[22] = mkv("clamp460",   0, 10'd0,   10'd100, 4'b0000,   1, 620, 460, 1, 9);
    vecs[23] = mkv("to_goal",    0, 10'h39C, 10'd0,   4'b0000,  16, 588, 460, 1, 9);
    vecs[24] = mkv("goal_win",   0, 10'h39C, 10'd0,   4'b0000,   1, 588, 460, 2, 9);
    vecs[25] = mkv("win_hold",   0, 10'h39C, 10'd100, 4'b0000, 119, 588, 460, 2, 9);
    vecs[26] = mkv("win_to_idle",0, 10'h39C, 10'd100, 4'b0000,   1,  40,   0, 0, 9);

    do_reset();
    check_a("rst_a", 40, 0, 0, 0);
    check_b("rst_b", 578, 446, 0, 0);

    for (int i = 0; i < 27; i++) begin
      set_in(vecs[i].xt, vecs[i].yt, vecs[i].stops);
      if (vecs[i].do_start) pulse_start(1'b0);
      for (int t = 0; t < vecs[i].nticks; t++) tick();
      check_a(vecs[i].name, vecs[i].ex, vecs[i].ey, vecs[i].est, vecs[i].esec);
    end

    // start coinciding with frame_tick: from IDLE no motion, in PLAY restart wins
    set_in(10'd100, 10'd0, 4'b0000);
    pulse_start(1'b1);
    check_a("idle_start_tick", 40, 0, 1, 0);
    tick(); tick();
    check_a("play_two", 44, 0, 1, 0);
    pulse_start(1'b1);
    check_a("restart_tick", 40, 0, 1, 0);
    set_in(10'd0, 10'd0, 4'b0000);
    for (int t = 0; t < 59; t++) tick();
    check_a("frame_reset59", 40, 0, 1, 0);
    tick();
    check_a("frame_reset60", 40, 0, 1, 1);

    // short timer: seconds step every 2 ticks, LOSE when seconds hits 3
    do_reset();
    set_in(10'd0, 10'd0, 4'b0000);
    pulse_start(1'b0);
    check_b("b_start", 578, 446, 1, 0);
    for (int t = 1; t <= 6; t++) begin
      tick();
      chk($sformatf("b_tmo_sec%0d", t), int'(secb), t / 2);
      chk($sformatf("b_tmo_st%0d", t),  int'(stb),  (t == 6) ? 3 : 1);
    end
    check_b("b_lose", 578, 446, 3, 3);
    pulse_start(1'b0);
    check_b("b_lose_restart", 578, 446, 1, 0);

    // enter goal on the same tick that would time out: WIN takes it
    set_in(10'd0, 10'd30, 4'b0000);
    for (int t = 0; t < 5; t++) tick();
    check_b("b_pre_goal", 578, 451, 1, 2);
    tick();
    check_b("b_goal_vs_tmo", 578, 451, 2, 2);
    for (int t = 0; t < 3; t++) tick();
    check_b("b_win_hold", 578, 451, 2, 2);
    tick();
    check_b("b_win_idle", 578, 446, 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
